mem_arbiter: RTL and testbench

Shares the single-ported system RAM between the instruction-fetch and data-access sides of the cache block. It sits between the cache interface (`iREN`/`dREN`/`dWEN`, `iwait`/`dwait`) and the RAM port, and grants one requester at a time. Data accesses have priority, and a bounded starvation counter guarantees forward progress for fetches. Grants are registered: once an access is issued it is held until the RAM reports completion, an error occurs, or the requester withdraws.

---
 rtl/cpu_types_pkg.sv | 19 +
 rtl/mem_arbiter_if.sv | 45 ++++
 rtl/mem_arbiter_starve_ctr.sv | 41 ++++
 rtl/mem_arbiter.sv | 118 +++++++++++
 tb/tb_mem_arbiter.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// ----------------------------------------------------------------------------
// cpu_types_pkg
// Purpose : Shared CPU-wide types used by the memory-side blocks.
//   word_t     - 32-bit machine word
//   ramstate_t - status reported by the RAM model each cycle
// Ports   : none (package)
// ----------------------------------------------------------------------------
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// ----------------------------------------------------------------------------
// mem_arbiter_if
// Purpose : Bundles the cache-side request/response signals and the RAM port
//           that the memory arbiter sits between.
// Signals : iREN/iaddr              instruction read request
//           dREN/dWEN/daddr/dstore  data read/write request
//           iwait/dwait, iload/dload  per-side completion and read data
//           ramREN/ramWEN/ramaddr/ramstore  RAM command
//           ramload/ramstate        RAM response
//           memerr                  sticky RAM error flag
// Modports: master - arbiter view (drives waits, load data and RAM command)
//           slave  - environment view (caches + RAM model)
// ----------------------------------------------------------------------------
interface mem_arbiter_if;
  import cpu_types_pkg::*;

  logic      iREN;
  word_t     iaddr;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      iwait;
  logic      dwait;
  word_t     iload;
  word_t     dload;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;
  logic      memerr;

  modport master (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, memerr
  );

  modport slave (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, memerr
  );

endinterface

// File: rtl/mem_arbiter_starve_ctr.sv
// ----------------------------------------------------------------------------
// starve_ctr
// Purpose : 4-bit counter that saturates at IMAX; sat tells the arbiter that
//           the instruction side has waited through IMAX data grants.
// Ports   : CLK  in  clock
//           nRST in  synchronous active-low reset
//           inc  in  count one data completion
//           clr  in  clear (has priority over inc)
//           sat  out count has reached IMAX
// ----------------------------------------------------------------------------
module starve_ctr #(
  parameter int IMAX = 4
) (
  input  logic CLK,
  input  logic nRST,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam logic [3:0] LIMIT = 4'(IMAX);

  logic [3:0] count_q;
  logic [3:0] count_d;

  always_ff @(posedge CLK) begin
    if (!nRST) count_q <= '0;
    else       count_q <= count_d;
  end

  always_comb begin
    count_d = count_q;
    if (clr)
      count_d = '0;
    else if (inc && (count_q < LIMIT))
      count_d = count_q + 4'd1;
  end

  assign sat = (count_q >= LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
// Purpose : Shares the single-ported RAM between instruction fetch and data
//           access. Data has priority; after IMAX consecutive data grants with
//           a fetch pending, the fetch is granted next. A grant is held until
//           the RAM reports ACCESS, reports ERROR, or the requester withdraws.
// Ports   : CLK   in  clock
//           nRST  in  synchronous active-low reset
//           bus   mem_arbiter_if.master (cache requests, RAM port, memerr)
// Param   : IMAX  consecutive data grants allowed while a fetch waits (1..15)
// ----------------------------------------------------------------------------
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int IMAX = 4
) (
  input  logic          CLK,
  input  logic          nRST,
  mem_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DGNT  = 2'd1,
    IGNT  = 2'd2,
    FAULT = 2'd3
  } arb_state_t;

  arb_state_t state_q;
  arb_state_t state_d;

  logic d_req;
  logic d_done;
  logic i_done;
  logic starve_sat;
  logic starve_inc;
  logic starve_clr;

  assign d_req  = bus.dREN | bus.dWEN;
  // A completion only counts while the granted side is still requesting;
  // a withdrawn request is an abort even if the RAM answers that cycle.
  assign d_done = (state_q == DGNT) && (bus.ramstate == ACCESS) && d_req;
  assign i_done = (state_q == IGNT) && (bus.ramstate == ACCESS) && bus.iREN;

  assign starve_inc = d_done & bus.iREN;
  assign starve_clr = i_done | ((state_q == IDLE) & ~bus.iREN);

  starve_ctr #(.IMAX(IMAX)) u_starve_ctr (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (starve_inc),
    .clr  (starve_clr),
    .sat  (starve_sat)
  );

  always_ff @(posedge CLK) begin
    if (!nRST) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // ERROR outranks everything in a grant state; an abort outranks ACCESS.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (d_req && (!starve_sat || !bus.iREN)) state_d = DGNT;
        else if (bus.iREN)                       state_d = IGNT;
      end
      DGNT: begin
        if (bus.ramstate == ERROR)         state_d = FAULT;
        else if (!d_req)                   state_d = IDLE;
        else if (bus.ramstate == ACCESS)   state_d = IDLE;
      end
      IGNT: begin
        if (bus.ramstate == ERROR)         state_d = FAULT;
        else if (!bus.iREN)                state_d = IDLE;
        else if (bus.ramstate == ACCESS)   state_d = IDLE;
      end
      FAULT: state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  // When both dREN and dWEN are set, the write wins and the read is masked.
  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.iwait    = 1'b1;
    bus.dwait    = 1'b1;
    bus.iload    = '0;
    bus.dload    = '0;
    bus.memerr   = (state_q == FAULT);
    unique case (state_q)
      DGNT: begin
        bus.ramWEN   = bus.dWEN;
        bus.ramREN   = bus.dREN & ~bus.dWEN;
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        if (d_done) begin
          bus.dwait = 1'b0;
          bus.dload = bus.ramload;
        end
      end
      IGNT: begin
        bus.ramREN  = 1'b1;
        bus.ramaddr = bus.iaddr;
        if (i_done) begin
          bus.iwait = 1'b0;
          bus.iload = bus.ramload;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_arbiter
// Purpose : Directed self-checking bench for mem_arbiter with IMAX=4. Inputs
//           are driven 2 time units after each rising edge and outputs are
//           compared 1 unit later, well clear of the next edge.
// ----------------------------------------------------------------------------
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic CLK;
  logic nRST;
  int   total;
  int   bad;

  mem_arbiter_if bus ();

  mem_arbiter #(.IMAX(4)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic applyStimulus(input logic iren, input logic [31:0] ia,
                               input logic dren, input logic dwen,
                               input logic [31:0] da, input logic [31:0] ds,
                               input ramstate_t rs, input logic [31:0] rl);
    bus.iREN     = iren;
    bus.iaddr    = ia;
    bus.dREN     = dren;
    bus.dWEN     = dwen;
    bus.daddr    = da;
    bus.dstore   = ds;
    bus.ramstate = rs;
    bus.ramload  = rl;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("[TB] FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic checkIdle(input string tag, input logic exp_err);
    checkOutput({tag, ".iwait"},   32'(bus.iwait),  32'd1);
    checkOutput({tag, ".dwait"},   32'(bus.dwait),  32'd1);
    checkOutput({tag, ".ramREN"},  32'(bus.ramREN), 32'd0);
    checkOutput({tag, ".ramWEN"},  32'(bus.ramWEN), 32'd0);
    checkOutput({tag, ".ramaddr"}, bus.ramaddr,     32'd0);
    checkOutput({tag, ".ramstore"}, bus.ramstore,   32'd0);
    checkOutput({tag, ".iload"},   bus.iload,       32'd0);
    checkOutput({tag, ".dload"},   bus.dload,       32'd0);
    checkOutput({tag, ".memerr"},  32'(bus.memerr), 32'(exp_err));
  endtask

  // With dREN, iREN and immediate ACCESS held, even cycles are IDLE and odd
  // cycles complete a grant: four data completions then one fetch, repeating.
  task automatic runStarvePattern(input int cycles, input string tag,
                                  input logic [31:0] ia, input logic [31:0] da,
                                  input logic [31:0] rl);
    logic        ew_i;
    logic        ew_d;
    logic [31:0] e_addr;
    for (int c = 0; c < cycles; c++) begin
      ew_i   = 1'b1;
      ew_d   = 1'b1;
      e_addr = 32'd0;
      if ((c % 2) == 1) begin
        if (((c / 2) % 5) == 4) begin
          ew_i   = 1'b0;
          e_addr = ia;
        end else begin
          ew_d   = 1'b0;
          e_addr = da;
        end
      end
      checkOutput($sformatf("%s[%0d].iwait", tag, c), 32'(bus.iwait), 32'(ew_i));
      checkOutput($sformatf("%s[%0d].dwait", tag, c), 32'(bus.dwait), 32'(ew_d));
      checkOutput($sformatf("%s[%0d].ramaddr", tag, c), bus.ramaddr, e_addr);
      checkOutput($sformatf("%s[%0d].dload", tag, c), bus.dload, ew_d ? 32'd0 : rl);
      checkOutput($sformatf("%s[%0d].iload", tag, c), bus.iload, ew_i ? 32'd0 : rl);
      tick();
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    nRST  = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, FREE, 0);

    // Reset state
    tick();
    checkIdle("reset", 1'b0);
    nRST = 1'b1;

    // Instruction only: ACCESS on the fourth grant cycle
    $display("[TB] instruction-only fetch");
    applyStimulus(1, 32'h40, 0, 0, 0, 0, FREE, 0);
    checkIdle("ifetch.req", 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 32'h40, 0, 0, 0, 0, BUSY, 32'h8C010004);
      checkOutput($sformatf("ifetch.busy%0d.ramREN", i), 32'(bus.ramREN), 32'd1);
      checkOutput($sformatf("ifetch.busy%0d.ramaddr", i), bus.ramaddr, 32'h40);
      checkOutput($sformatf("ifetch.busy%0d.iwait", i), 32'(bus.iwait), 32'd1);
      checkOutput($sformatf("ifetch.busy%0d.iload", i), bus.iload, 32'd0);
      tick();
    end
    applyStimulus(1, 32'h40, 0, 0, 0, 0, ACCESS, 32'h8C010004);
    checkOutput("ifetch.done.iwait",   32'(bus.iwait), 32'd0);
    checkOutput("ifetch.done.iload",   bus.iload,      32'h8C010004);
    checkOutput("ifetch.done.ramaddr", bus.ramaddr,    32'h40);
    checkOutput("ifetch.done.dwait",   32'(bus.dwait), 32'd1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, FREE, 0);
    checkIdle("ifetch.after", 1'b0);
    tick();

    // Simultaneous request: data first, fetch after one IDLE cycle
    $display("[TB] simultaneous request");
    applyStimulus(1, 32'h44, 1, 0, 32'h100, 0, FREE, 0);
    checkIdle("simul.req", 1'b0);
    tick();
    applyStimulus(1, 32'h44, 1, 0, 32'h100, 0, ACCESS, 32'h11112222);
    checkOutput("simul.d.dwait",   32'(bus.dwait),  32'd0);
    checkOutput("simul.d.dload",   bus.dload,       32'h11112222);
    checkOutput("simul.d.ramaddr", bus.ramaddr,     32'h100);
    checkOutput("simul.d.ramREN",  32'(bus.ramREN), 32'd1);
    checkOutput("simul.d.iwait",   32'(bus.iwait),  32'd1);
    tick();
    // ACCESS while IDLE must be ignored
    applyStimulus(1, 32'h44, 0, 0, 0, 0, ACCESS, 32'h33334444);
    checkIdle("simul.turn", 1'b0);
    tick();
    applyStimulus(1, 32'h44, 0, 0, 0, 0, ACCESS, 32'h33334444);
    checkOutput("simul.i.iwait",   32'(bus.iwait), 32'd0);
    checkOutput("simul.i.iload",   bus.iload,      32'h33334444);
    checkOutput("simul.i.ramaddr", bus.ramaddr,    32'h44);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, FREE, 0);
    checkIdle("simul.after", 1'b0);
    tick();

    // Starvation with IMAX=4
    $display("[TB] starvation pattern");
    applyStimulus(1, 32'h48, 1, 0, 32'h100, 0, ACCESS, 32'hA5A5A5A5);
    runStarvePattern(20, "starve", 32'h48, 32'h100, 32'hA5A5A5A5);
    applyStimulus(0, 0, 0, 0, 0, 0, FREE, 0);
    checkIdle("starve.after", 1'b0);
    tick();

    // Write
    $display("[TB] data write");
    applyStimulus(0, 0, 0, 1, 32'h200, 32'hDEADBEEF, FREE, 0);
    checkIdle("write.req", 1'b0);
    tick();
    applyStimulus(0, 0, 0, 1, 32'h200, 32'hDEADBEEF, BUSY, 0);
    checkOutput("write.busy.ramWEN",   32'(bus.ramWEN), 32'd1);
    checkOutput("write.busy.ramREN",   32'(bus.ramREN), 32'd0);
    checkOutput("write.busy.ramaddr",  bus.ramaddr,     32'h200);
    checkOutput("write.busy.ramstore", bus.ramstore,    32'hDEADBEEF);
    checkOutput("write.busy.dwait",    32'(bus.dwait),  32'd1);
    tick();
    applyStimulus(0, 0, 0, 1, 32'h200, 32'hDEADBEEF, ACCESS, 0);
    checkOutput("write.done.dwait",    32'(bus.dwait),  32'd0);
    checkOutput("write.done.ramWEN",   32'(bus.ramWEN), 32'd1);
    checkOutput("write.done.ramstore", bus.ramstore,    32'hDEADBEEF);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, FREE, 0);
    checkIdle("write.after", 1'b0);
    tick();

    // Read and write together: write wins
    applyStimulus(0, 0, 1, 1, 32'h204, 32'h12345678, FREE, 0);
    tick();
    applyStimulus(0, 0, 1, 1, 32'h204, 32'h12345678, ACCESS, 0);
    checkOutput("rw.ramWEN",   32'(bus.ramWEN), 32'd1);
    checkOutput("rw.ramREN",   32'(bus.ramREN), 32'd0);
    checkOutput("rw.ramstore", bus.ramstore,    32'h12345678);
    checkOutput("rw.dwait",    32'(bus.dwait),  32'd0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, FREE, 0);
    checkIdle("rw.after", 1'b0);
    tick();

    // Abort: dREN dropped while BUSY
    $display("[TB] abort");
    applyStimulus(0, 0, 1, 0, 32'h300, 0, FREE, 0);
    tick();
    applyStimulus(0, 0, 1, 0, 32'h300, 0, BUSY, 0);
    checkOutput("abort.busy.ramREN", 32'(bus.ramREN), 32'd1);
    checkOutput("abort.busy.dwait",  32'(bus.dwait),  32'd1);
    tick();
    applyStimulus(0, 0, 0, 0, 32'h300, 0, BUSY, 0);
    checkOutput("abort.drop.dwait",  32'(bus.dwait),  32'd1);
    checkOutput("abort.drop.ramREN", 32'(bus.ramREN), 32'd0);
    tick();
    // Back in IDLE: a new fetch is granted next cycle
    applyStimulus(1, 32'h50, 0, 0, 0, 0, ACCESS, 32'hCAFE0001);
    checkIdle("abort.idle", 1'b0);
    tick();
    applyStimulus(1, 32'h50, 0, 0, 0, 0, ACCESS, 32'hCAFE0001);
    checkOutput("abort.i.iwait",   32'(bus.iwait),  32'd0);
    checkOutput("abort.i.iload",   bus.iload,       32'hCAFE0001);
    checkOutput("abort.i.ramaddr", bus.ramaddr,     32'h50);
    checkOutput("abort.i.dwait",   32'(bus.dwait),  32'd1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, FREE, 0);
    checkIdle("abort.after", 1'b0);
    tick();

    // Reset mid-grant after two data completions
    $display("[TB] reset mid-grant");
    applyStimulus(1, 32'h60, 1, 0, 32'h400, 0, ACCESS, 32'h0BADF00D);
    runStarvePattern(5, "pre", 32'h60, 32'h400, 32'h0BADF00D);
    applyStimulus(1, 32'h60, 1, 0, 32'h400, 0, BUSY, 32'h0BADF00D);
    checkOutput("rstgnt.ramREN",  32'(bus.ramREN), 32'd1);
    checkOutput("rstgnt.ramaddr", bus.ramaddr,     32'h400);
    checkOutput("rstgnt.dwait",   32'(bus.dwait),  32'd1);
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    applyStimulus(1, 32'h60, 1, 0, 32'h400, 0, ACCESS, 32'h0BADF00D);
    checkIdle("rstgnt.idle", 1'b0);
    runStarvePattern(10, "post", 32'h60, 32'h400, 32'h0BADF00D);

    // Error during instruction grant
    $display("[TB] error");
    applyStimulus(1, 32'h70, 0, 0, 0, 0, FREE, 0);
    checkIdle("err.req", 1'b0);
    tick();
    applyStimulus(1, 32'h70, 0, 0, 0, 0, ERROR, 0);
    checkOutput("err.gnt.memerr", 32'(bus.memerr), 32'd0);
    checkOutput("err.gnt.iwait",  32'(bus.iwait),  32'd1);
    checkOutput("err.gnt.ramREN", 32'(bus.ramREN), 32'd1);
    tick();
    applyStimulus(1, 32'h70, 0, 0, 0, 0, FREE, 0);
    checkIdle("err.fault0", 1'b1);
    tick();
    applyStimulus(1, 32'h70, 1, 0, 32'h500, 0, ACCESS, 32'h55AA55AA);
    checkIdle("err.fault1", 1'b1);
    tick();
    checkIdle("err.fault2", 1'b1);
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, FREE, 0);
    checkIdle("err.reset", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
